// File: rtl/uart_rx_fifo.sv
// 4x-oversampled 8N1 UART receiver feeding a byte FIFO, with RTS flow control.
// Define UART_RX_FRAMING_EN to check the stop bit (ferr flag and BRK state).
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int RTS_LEVEL = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_clk4x,
  input  logic       rx,
  input  logic       data_read,
  output logic [7:0] rxdata,
  output logic       rxrecv,
  output logic       ovf,
  output logic       ferr,
  output logic       rts
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;
  localparam logic [PW:0] RTS_CNT = (PW+1)'(RTS_LEVEL);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
`ifdef UART_RX_FRAMING_EN
  localparam logic [2:0] BRK   = 3'd4;
`endif

  logic        rxMeta_q, rxSync_q;
  logic [2:0]  state_q, state_d;
  logic [1:0]  tcnt_q, tcnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_q, push_d;
  logic        dataRead_q, pop_q;
  logic [PW:0] rdPtr_q, wrPtr_q, count_q, count_d;
  logic [7:0]  mem_q [DEPTH];
  logic        ovf_q, rts_q;
  logic        full, empty, doPush, doPop, ovfSet;
`ifdef UART_RX_FRAMING_EN
  logic        ferrSet, ferr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  // Start bit is rechecked two ticks in; data and stop bits every four ticks after that.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    push_d   = 1'b0;
`ifdef UART_RX_FRAMING_EN
    ferrSet  = 1'b0;
`endif
    if (bit_clk4x) begin
      case (state_q)
        IDLE: begin
          if (!rxSync_q) begin
            state_d = START;
            tcnt_d  = 2'd0;
          end
        end
        START: begin
          tcnt_d = tcnt_q + 2'd1;
          if (tcnt_q == 2'd1) begin
            if (!rxSync_q) begin
              state_d  = DATA;
              tcnt_d   = 2'd0;
              bitcnt_d = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          tcnt_d = tcnt_q + 2'd1;
          if (tcnt_q == 2'd3) begin
            shift_d  = {rxSync_q, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_d = STOP;
          end
        end
        STOP: begin
          tcnt_d = tcnt_q + 2'd1;
          if (tcnt_q == 2'd3) begin
`ifdef UART_RX_FRAMING_EN
            if (rxSync_q) begin
              push_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ferrSet = 1'b1;
              state_d = BRK;
            end
`else
            push_d  = 1'b1;
            state_d = IDLE;
`endif
          end
        end
`ifdef UART_RX_FRAMING_EN
        BRK: begin
          if (rxSync_q) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when a pop lands in the same cycle.
  assign empty  = (count_q == '0);
  assign full   = (wrPtr_q[PW] != rdPtr_q[PW]) && (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
  assign doPop  = pop_q && !empty;
  assign doPush = push_q && (!full || doPop);
  assign ovfSet = push_q && full && !doPop;

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) count_d = count_q + PTR_ONE;
    else if (doPop && !doPush) count_d = count_q - PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tcnt_q     <= 2'd0;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      push_q     <= 1'b0;
      dataRead_q <= 1'b0;
      pop_q      <= 1'b0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rts_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      push_q     <= push_d;
      dataRead_q <= data_read;
      pop_q      <= dataRead_q && !data_read;
      if (doPop) rdPtr_q <= rdPtr_q + PTR_ONE;
      if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
      count_q    <= count_d;
      if (ovfSet) ovf_q <= 1'b1;
      else if (pop_q) ovf_q <= 1'b0;
      rts_q      <= (count_q >= RTS_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[PW-1:0]] <= shift_q;
  end

`ifdef UART_RX_FRAMING_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ferr_q <= 1'b0;
    end else if (ferrSet) begin
      ferr_q <= 1'b1;
    end else if (pop_q) begin
      ferr_q <= 1'b0;
    end
  end
  assign ferr = ferr_q;
`else
  assign ferr = 1'b0;
`endif

  assign rxdata = empty ? 8'h00 : mem_q[rdPtr_q[PW-1:0]];
  assign rxrecv = !empty;
  assign ovf    = ovf_q;
  assign rts    = rts_q;

endmodule
